// File: rtl/oam_dma.sv
// $4014 sprite DMA: halts the CPU via cpu_ce and copies page {P,00..FF} into OAM at oam_base+idx.
// Stall is 513 ticks (514 from an odd trigger cycle); each byte is one RD tick plus one WR tick; no backpressure.
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter int          XFER_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [15:0] cpu_ea,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wreq,
    output logic        cpu_ce,
    output logic [15:0] dma_addr,
    output logic        dma_sel,
    input  logic [7:0]  mem_din,
    input  logic [7:0]  oam_base,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        busy
);
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} state_t;

    state_t     state_q, state_d;
    logic       par_q;
    logic       rd_first_q;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] base_q, base_d;
    logic [7:0] data_q;
    logic [7:0] oam_addr_q, oam_addr_d;
    logic [7:0] oam_data_q, oam_data_d;
    logic       oam_we_q, oam_we_d;

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        base_d     = base_q;
        oam_addr_d = oam_addr_q;
        oam_data_d = oam_data_q;
        oam_we_d   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (cpu_wreq && cpu_ea == DMA_REG) begin
                        page_d  = cpu_dout;
                        idx_d   = 8'h00;
                        base_d  = oam_base;
                        state_d = HALT;
                    end
                end
                // par_q flipped on the trigger tick: 0 here means the trigger landed on an odd cycle.
                HALT:    state_d = par_q ? RD : ALIGN;
                ALIGN:   state_d = RD;
                RD:      state_d = WR;
                WR: begin
                    oam_addr_d = base_q + idx_q;
                    oam_data_d = data_q;
                    oam_we_d   = 1'b1;
                    idx_d      = idx_q + 8'h01;
                    state_d    = (idx_q == LAST_IDX) ? IDLE : RD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            par_q      <= 1'b0;
            rd_first_q <= 1'b0;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            base_q     <= 8'h00;
            data_q     <= 8'h00;
            oam_addr_q <= 8'h00;
            oam_data_q <= 8'h00;
            oam_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (tick) par_q <= ~par_q;
            rd_first_q <= (state_d == RD) && (state_q != RD);
            page_q     <= page_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            // mem_din is valid one clk after dma_addr settles, i.e. on the first clk spent in RD.
            if (state_q == RD && rd_first_q) data_q <= mem_din;
            oam_addr_q <= oam_addr_d;
            oam_data_q <= oam_data_d;
            oam_we_q   <= oam_we_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign cpu_ce   = (state_q == IDLE);
    assign dma_sel  = (state_q == RD) || (state_q == WR);
    assign dma_addr = dma_sel ? {page_q, idx_q} : 16'h0000;
    assign oam_addr = oam_addr_q;
    assign oam_data = oam_data_q;
    assign oam_we   = oam_we_q;
endmodule

// File: tb/tb_oam_dma.sv
// Scoreboarded bench for oam_dma: directed $4014 transfers, queued expectations checked by a negedge monitor.
module tb_oam_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] cpu_ea = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_wreq = 1'b0;
    logic        cpu_ce;
    logic [15:0] dma_addr;
    logic        dma_sel;
    logic [7:0]  mem_din;
    logic [7:0]  oam_base = 8'h00;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we;
    logic        busy;

    logic [7:0]  mem [0:65535];
    assign mem_din = mem[dma_addr];

    oam_dma dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cpu_ea(cpu_ea), .cpu_dout(cpu_dout),
        .cpu_wreq(cpu_wreq), .cpu_ce(cpu_ce), .dma_addr(dma_addr), .dma_sel(dma_sel),
        .mem_din(mem_din), .oam_base(oam_base), .oam_addr(oam_addr), .oam_data(oam_data),
        .oam_we(oam_we), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    int we_cnt = 0;
    int stall = 0;
    int pre = 0;
    logic sel_prev = 1'b0;
    logic [15:0] addr_prev = 16'h0000;
    int tp = 2;
    int ph = 0;
    int tick_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes OAM or moves its read address.
    always @(negedge clk) begin
        if (!rst_n) begin
            sel_prev = 1'b0;
        end else begin
            if (tick && !cpu_ce) begin
                stall++;
                if (!dma_sel) pre++;
            end
            if (oam_we) begin
                we_cnt++;
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL oam_we_unexpected: got addr %h data %h with nothing expected", oam_addr, oam_data);
                end else begin
                    logic [15:0] e;
                    e = exp_wr_q.pop_front();
                    if ({oam_addr, oam_data} !== e) begin
                        errors++;
                        $display("FAIL oam_wr: got %h expected %h", {oam_addr, oam_data}, e);
                    end
                end
            end
            if (dma_sel && (!sel_prev || dma_addr != addr_prev)) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL dma_addr_unexpected: got %h with nothing expected", dma_addr);
                end else begin
                    logic [15:0] e;
                    e = exp_rd_q.pop_front();
                    if (dma_addr !== e) begin
                        errors++;
                        $display("FAIL dma_addr: got %h expected %h", dma_addr, e);
                    end
                end
            end
            sel_prev  = dma_sel;
            addr_prev = dma_addr;
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
        if (tick && rst_n) tick_cnt++;
        cpu_wreq = 1'b0;
        ph = (ph + 1) % tp;
        tick = rst_n && (ph == 0);
    endtask

    // Issue a CPU write on the next tick whose parity matches p (p<0: any tick).
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int p);
        adv();
        while (!(tick && (p < 0 || (tick_cnt % 2) == p))) adv();
        cpu_wreq = 1'b1;
        cpu_ea   = a;
        cpu_dout = d;
    endtask

    task automatic push_xfer(input logic [7:0] page, input logic [7:0] base);
        for (int i = 0; i < 256; i++) begin
            exp_wr_q.push_back({8'(base + 8'(i)), mem[{page, 8'(i)}]});
            exp_rd_q.push_back({page, 8'(i)});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        adv();
        while (busy && n < 6000) begin
            adv();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout: busy still %b after %0d clks, required 0", name, busy, n);
        end
        repeat (3) adv();
    endtask

    task automatic run(input string name, input logic [7:0] page, input logic [7:0] base,
                       input int p, input int exp_stall, input int exp_pre);
        int we0;
        oam_base = base;
        push_xfer(page, base);
        stall = 0;
        pre = 0;
        we0 = we_cnt;
        wr(16'h4014, page, p);
        wait_idle(name);
        check({name, "_stall"}, stall, exp_stall);
        check({name, "_pre_read"}, pre, exp_pre);
        check({name, "_we_count"}, we_cnt - we0, 256);
        check({name, "_leftover"}, exp_wr_q.size() + exp_rd_q.size(), 0);
        check({name, "_idle_outs"}, {cpu_ce, busy, dma_sel, dma_addr}, {1'b1, 1'b0, 1'b0, 16'h0000});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_cnt = 0;
        ph = 0;
        tick = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_snap;
        int n;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 13 + 7);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
            mem[16'h0300 + i] = ~8'(i);
            mem[16'hFF00 + i] = 8'(i * 7 + 1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {cpu_ce, dma_sel, oam_we, busy, dma_addr}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        check("reset_oam", {oam_addr, oam_data}, 16'h0000);
        do_reset();

        // Even and odd trigger cycles; wrap of oam_addr past 8'hFF
        tp = 2;
        run("even", 8'h02, 8'h00, 0, 513, 1);
        run("odd", 8'h02, 8'h00, 1, 514, 2);
        run("base_f0", 8'h02, 8'hF0, 0, 513, 1);

        // Stretched ticks; foreign register and a second $4014 during busy must be ignored
        tp = 4;
        wr(16'h4015, 8'h07, -1);
        repeat (8) adv();
        check("ignore_4015_idle", {busy, cpu_ce}, {1'b0, 1'b1});
        oam_base = 8'h00;
        push_xfer(8'h03, 8'h00);
        stall = 0;
        pre = 0;
        we_snap = we_cnt;
        wr(16'h4014, 8'h03, 0);
        wr(16'h4015, 8'h07, -1);
        wr(16'h4014, 8'h05, -1);
        wait_idle("stretch");
        check("stretch_stall", stall, 513);
        check("stretch_we_count", we_cnt - we_snap, 256);
        repeat (40) adv();
        check("stretch_no_restart", {busy, 32'(we_cnt - we_snap)}, {1'b0, 32'd256});

        // Reset in the middle of a transfer, then a clean restart
        tp = 2;
        oam_base = 8'h00;
        we_snap = we_cnt;
        push_xfer(8'h02, 8'h00);
        wr(16'h4014, 8'h02, 0);
        n = 0;
        while (we_cnt - we_snap < 100 && n < 4000) begin
            adv();
            n++;
        end
        check("mid_we_reached", we_cnt - we_snap, 100);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outs", {busy, cpu_ce, dma_sel, oam_we}, {1'b0, 1'b1, 1'b0, 1'b0});
        exp_wr_q.delete();
        exp_rd_q.delete();
        we_snap = we_cnt;
        do_reset();
        repeat (100) adv();
        check("post_reset_quiet", {busy, 32'(we_cnt - we_snap)}, {1'b0, 32'd0});
        run("restart", 8'h02, 8'h00, 0, 513, 1);

        // Top page: addresses FF00..FFFF, no carry out of the page
        tp = 3;
        run("page_ff", 8'hFF, 8'h00, 1, 514, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
